parc_core_reorder_buffer: RTL and testbench
===========================================

PARC_CORE_REORDER_BUFFER -- requirements
Module: parc_core_reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries; slot index width fixed at 4 bits.
REQ-002 SHALL have clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have rob_alloc_req_val  input  1  decode requests a slot for an issuing instruction.
REQ-005 SHALL have rob_alloc_req_preg  input  5  destination architectural register of the allocating instruction.
REQ-006 SHALL have rob_alloc_req_rdy  output  1  a slot is free this cycle.
REQ-007 SHALL have rob_alloc_resp_slot  output  4  slot granted; always equals tail pointer; sent to the scoreboard as its rob_alloc_slot.
REQ-008 SHALL have rob_fill_val  input  1  writeback stage delivers a result.
REQ-009 SHALL have rob_fill_slot  input  4  slot being filled.
REQ-010 SHALL have rob_fill_data  input  32  result value.
REQ-011 SHALL have src0_byp_rob_slot / src1_byp_rob_slot  input  4 each  bypass read addresses from the scoreboard.
REQ-012 SHALL have src0_byp_data / src1_byp_data  output  32 each  stored data of the addressed slot.
REQ-013 SHALL have rob_commit_wen  output  1  head entry retires this cycle; feeds scoreboard rob_commit_wen.
REQ-014 SHALL have rob_commit_slot  output  4  head pointer; feeds scoreboard rob_commit_slot.
REQ-015 SHALL have commit_rf_wen / commit_rf_waddr / commit_rf_wdata  output  1/5/32  register-file write of the retiring entry.

Function
REQ-016 SHALL hold per-entry state: valid, pending, preg[4:0], data[31:0]; plus head[3:0], tail[3:0], count[4:0].
REQ-017 SHALL drive rob_alloc_req_rdy = !reset && (count < 16), from registered count only; a same-cycle commit SHALL NOT open a slot.
REQ-018 SHALL on alloc fire (val && rdy): set entry[tail] valid=1, pending=1, preg=rob_alloc_req_preg; tail <= tail+1 mod 16.
REQ-019 SHALL on rob_fill_val with entry[rob_fill_slot].valid=1: pending <= 0, data <= rob_fill_data; fill to an invalid slot SHALL be ignored.
REQ-020 SHALL assert rob_commit_wen combinationally iff entry[head].valid && !entry[head].pending (registered state); at most one commit per cycle, strictly in order.
REQ-021 SHALL on commit: entry[head].valid <= 0, head <= head+1 mod 16.
REQ-022 SHALL drive commit_rf_wen = rob_commit_wen && (preg[head] != 0); commit_rf_waddr = preg[head]; commit_rf_wdata = data[head].
REQ-023 SHALL update count <= count + alloc_fire - commit; simultaneous alloc and commit leave count unchanged.
REQ-024 SHALL commit a filled head no earlier than the cycle after the fill (fill-to-commit latency 1 cycle); no same-cycle fill-to-commit forwarding.
REQ-025 SHALL drive srcN_byp_data = data[srcN_byp_rob_slot] combinationally from registered state; same-cycle fill data SHALL NOT be forwarded.
REQ-026 SHALL accept alloc, fill and commit in the same cycle on the same or different slots without interaction beyond REQ-019..024.
REQ-027 SHALL wrap head and tail from 15 to 0; full when count=16 (head==tail), empty when count=0 (head==tail).

Reset
REQ-028 SHALL on reset clear head, tail, count and every valid/pending bit; data/preg need not reset.
REQ-029 SHALL drive during and after reset: rob_alloc_req_rdy=0 during reset then 1, rob_alloc_resp_slot=0, rob_commit_wen=0, commit_rf_wen=0.
REQ-030 SHALL abandon in-flight entries on reset mid-operation; fills arriving after reset to stale slots SHALL be ignored.

Verification
REQ-031 SHALL verify alloc preg=5 -> slot 0; fill slot 0 data 0xDEADBEEF next cycle -> following cycle rob_commit_wen=1, slot 0, commit_rf_waddr=5, wdata=0xDEADBEEF.
REQ-032 SHALL verify out-of-order fill: alloc slots 0,1,2; fill 2 then 1 then 0 -> commits of 0,1,2 on three consecutive cycles after fill of 0.
REQ-033 SHALL verify 16 allocs with no fills -> rdy=0, count=16; 17th request not granted; fill+commit slot 0 -> rdy=1 the cycle after commit; next slot granted = 0 (wrap).
REQ-034 SHALL verify alloc preg=0, fill -> rob_commit_wen=1, commit_rf_wen=0.
REQ-035 SHALL verify bypass: fill slot 3 data 0x1234 -> next cycle src1_byp_rob_slot=3 returns 0x1234; same-cycle read returns old data.
REQ-036 SHALL verify reset with 6 entries in flight -> rdy=1, head=tail=0, no commits; fill to slot 4 after reset produces no commit.

Source files
------------

// File: rtl/parc_core_reorder_buffer_if.sv
// Allocation, writeback-fill, bypass-read and commit signals of the reorder buffer.
// The master side is the decode/writeback/scoreboard environment; the slave side is the ROB.
interface parc_core_reorder_buffer_if;
    logic        rob_alloc_req_val;
    logic [4:0]  rob_alloc_req_preg;
    logic        rob_alloc_req_rdy;
    logic [3:0]  rob_alloc_resp_slot;

    logic        rob_fill_val;
    logic [3:0]  rob_fill_slot;
    logic [31:0] rob_fill_data;

    logic [3:0]  src0_byp_rob_slot;
    logic [3:0]  src1_byp_rob_slot;
    logic [31:0] src0_byp_data;
    logic [31:0] src1_byp_data;

    logic        rob_commit_wen;
    logic [3:0]  rob_commit_slot;
    logic        commit_rf_wen;
    logic [4:0]  commit_rf_waddr;
    logic [31:0] commit_rf_wdata;

    modport master (
        output rob_alloc_req_val, rob_alloc_req_preg,
        input  rob_alloc_req_rdy, rob_alloc_resp_slot,
        output rob_fill_val, rob_fill_slot, rob_fill_data,
        output src0_byp_rob_slot, src1_byp_rob_slot,
        input  src0_byp_data, src1_byp_data,
        input  rob_commit_wen, rob_commit_slot,
        input  commit_rf_wen, commit_rf_waddr, commit_rf_wdata
    );

    modport slave (
        input  rob_alloc_req_val, rob_alloc_req_preg,
        output rob_alloc_req_rdy, rob_alloc_resp_slot,
        input  rob_fill_val, rob_fill_slot, rob_fill_data,
        input  src0_byp_rob_slot, src1_byp_rob_slot,
        output src0_byp_data, src1_byp_data,
        output rob_commit_wen, rob_commit_slot,
        output commit_rf_wen, commit_rf_waddr, commit_rf_wdata
    );
endinterface

// File: rtl/parc_core_reorder_buffer.sv
// In-order-commit reorder buffer: allocates slots at the tail, accepts out-of-order fills,
// and retires at most one filled head entry per cycle into the register file.
module parc_core_reorder_buffer #(
    parameter int unsigned ROB_DEPTH = 16
) (
    input logic                       clk,
    input logic                       reset,
    parc_core_reorder_buffer_if.slave rob
);
    localparam int unsigned SLOT_W = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PREG_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(ROB_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] pending_q;
    logic [PREG_W-1:0]    preg_q [ROB_DEPTH];
    logic [DATA_W-1:0]    data_q [ROB_DEPTH];
    logic [SLOT_W-1:0]    head_q;
    logic [SLOT_W-1:0]    tail_q;
    logic [CNT_W-1:0]     count_q;

    logic alloc_rdy_c;
    logic alloc_fire_c;
    logic commit_c;
    logic fill_hit_c;

    function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + SLOT_W'(1);
    endfunction

    // Handshake decisions come from registered state only; a commit this cycle does not free a slot.
    always_comb begin
        alloc_rdy_c  = !reset && (count_q < FULL_CNT);
        alloc_fire_c = rob.rob_alloc_req_val && alloc_rdy_c;
        commit_c     = !reset && valid_q[head_q] && !pending_q[head_q];
        fill_hit_c   = rob.rob_fill_val && valid_q[rob.rob_fill_slot];
    end

    assign rob.rob_alloc_req_rdy   = alloc_rdy_c;
    assign rob.rob_alloc_resp_slot = tail_q;
    assign rob.rob_commit_wen      = commit_c;
    assign rob.rob_commit_slot     = head_q;
    assign rob.commit_rf_wen       = commit_c && (preg_q[head_q] != '0);
    assign rob.commit_rf_waddr     = preg_q[head_q];
    assign rob.commit_rf_wdata     = data_q[head_q];
    assign rob.src0_byp_data       = data_q[rob.src0_byp_rob_slot];
    assign rob.src1_byp_data       = data_q[rob.src1_byp_rob_slot];

    // Control state; alloc and commit never target the same slot because a full buffer refuses alloc.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            if (fill_hit_c) begin
                pending_q[rob.rob_fill_slot] <= 1'b0;
            end
            if (commit_c) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            if (alloc_fire_c) begin
                valid_q[tail_q]   <= 1'b1;
                pending_q[tail_q] <= 1'b1;
                tail_q            <= ptr_inc(tail_q);
            end
            count_q <= count_q + CNT_W'(alloc_fire_c) - CNT_W'(commit_c);
        end
    end

    // Payload storage is left unreset; valid bits alone decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (fill_hit_c) begin
            data_q[rob.rob_fill_slot] <= rob.rob_fill_data;
        end
        if (alloc_fire_c) begin
            preg_q[tail_q] <= rob.rob_alloc_req_preg;
        end
    end
endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Directed and randomized checks of the reorder buffer against a queue-based model of
// in-flight instructions in program order.
module tb_parc_core_reorder_buffer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    parc_core_reorder_buffer_if rob ();

    parc_core_reorder_buffer #(.ROB_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rob)
    );

    typedef struct {
        int          slot;
        logic [4:0]  preg;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    ent_t        q[$];
    int          allocs  = 0;
    int          commits = 0;
    logic [31:0] mem   [16];
    bit          known [16];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit av, input logic [4:0] ap,
                         input bit fv, input logic [3:0] fs, input logic [31:0] fd,
                         input logic [3:0] s0, input logic [3:0] s1);
        reset                  = rst;
        rob.rob_alloc_req_val  = av;
        rob.rob_alloc_req_preg = ap;
        rob.rob_fill_val       = fv;
        rob.rob_fill_slot      = fs;
        rob.rob_fill_data      = fd;
        rob.src0_byp_rob_slot  = s0;
        rob.src1_byp_rob_slot  = s1;
    endtask

    // One clock: drive, compare against the model's pre-edge view, clock, advance the model.
    task automatic cycle(input bit rst, input bit av, input logic [4:0] ap,
                         input bit fv, input logic [3:0] fs, input logic [31:0] fd,
                         input logic [3:0] s0, input logic [3:0] s1);
        bit   exp_rdy;
        bit   exp_commit;
        ent_t e;
        drive(rst, av, ap, fv, fs, fd, s0, s1);
        #1;
        exp_rdy    = !rst && (q.size() < 16);
        exp_commit = !rst && (q.size() > 0) && q[0].filled;
        chk("rdy", 32'(rob.rob_alloc_req_rdy), 32'(exp_rdy));
        chk("commit_wen", 32'(rob.rob_commit_wen), 32'(exp_commit));
        if (!rst) begin
            chk("resp_slot", 32'(rob.rob_alloc_resp_slot), 32'(allocs % 16));
            chk("commit_slot", 32'(rob.rob_commit_slot), 32'(commits % 16));
        end
        if (exp_commit) begin
            chk("rf_wen", 32'(rob.commit_rf_wen), 32'(q[0].preg != 5'd0));
            chk("rf_waddr", 32'(rob.commit_rf_waddr), 32'(q[0].preg));
            chk("rf_wdata", rob.commit_rf_wdata, q[0].data);
        end else begin
            chk("rf_wen_idle", 32'(rob.commit_rf_wen), 32'd0);
        end
        if (known[s0]) chk("byp0", rob.src0_byp_data, mem[s0]);
        if (known[s1]) chk("byp1", rob.src1_byp_data, mem[s1]);
        @(posedge clk);
        if (rst) begin
            q.delete();
            allocs  = 0;
            commits = 0;
            for (int i = 0; i < 16; i++) known[i] = 1'b0;
        end else begin
            if (fv) begin
                foreach (q[i]) begin
                    if (q[i].slot == int'(fs)) begin
                        q[i].filled = 1'b1;
                        q[i].data   = fd;
                        mem[fs]     = fd;
                        known[fs]   = 1'b1;
                    end
                end
            end
            if (exp_commit) begin
                void'(q.pop_front());
                commits++;
            end
            if (av && exp_rdy) begin
                e.slot   = allocs % 16;
                e.preg   = ap;
                e.data   = 32'h0;
                e.filled = 1'b0;
                q.push_back(e);
                allocs++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    endtask
    task automatic do_reset();
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    endtask
    task automatic alloc(input logic [4:0] p);
        cycle(1'b0, 1'b1, p, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    endtask
    task automatic fill(input logic [3:0] s, input logic [31:0] d);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, s, d, 4'd0, 4'd0);
    endtask
    task automatic peek();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        #1;
    endtask

    initial begin
        logic [3:0] fs;
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();

        // single instruction: alloc, fill, commit one cycle later
        alloc(5'd5);
        fill(4'd0, 32'hDEADBEEF);
        peek();
        chk("d_commit_wen", 32'(rob.rob_commit_wen), 32'd1);
        chk("d_commit_slot", 32'(rob.rob_commit_slot), 32'd0);
        chk("d_waddr", 32'(rob.commit_rf_waddr), 32'd5);
        chk("d_wdata", rob.commit_rf_wdata, 32'hDEADBEEF);
        idle();

        // preg 0 commit, refill of a filled slot, and bypass timing
        alloc(5'd0);
        alloc(5'd9);
        alloc(5'd3);
        fill(4'd3, 32'hAAAA0003);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd3, 32'h00001234, 4'd0, 4'd3);
        #1;
        chk("d_byp_same_cycle", rob.src1_byp_data, 32'hAAAA0003);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 4'd3, 32'h00001234, 4'd0, 4'd3);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd3);
        #1;
        chk("d_byp_next_cycle", rob.src1_byp_data, 32'h00001234);
        fill(4'd1, 32'h00000077);
        peek();
        chk("d_p0_commit_wen", 32'(rob.rob_commit_wen), 32'd1);
        chk("d_p0_rf_wen", 32'(rob.commit_rf_wen), 32'd0);
        idle();
        fill(4'd2, 32'h00000222);
        repeat (3) idle();

        // out-of-order fills retire in order on consecutive cycles
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        fill(4'd2, 32'h22);
        fill(4'd1, 32'h11);
        fill(4'd0, 32'h00);
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("d_ooo_wen", 32'(rob.rob_commit_wen), 32'd1);
            chk("d_ooo_slot", 32'(rob.rob_commit_slot), 32'(i));
            idle();
        end

        // full buffer, refused request, commit does not open a slot until the next cycle, wrap
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1));
        peek();
        chk("d_full_rdy", 32'(rob.rob_alloc_req_rdy), 32'd0);
        alloc(5'd31);
        fill(4'd0, 32'h0000F00D);
        drive(1'b0, 1'b1, 5'd30, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        #1;
        chk("d_full_commit_wen", 32'(rob.rob_commit_wen), 32'd1);
        chk("d_full_commit_rdy", 32'(rob.rob_alloc_req_rdy), 32'd0);
        alloc(5'd30);
        peek();
        chk("d_reopen_rdy", 32'(rob.rob_alloc_req_rdy), 32'd1);
        chk("d_wrap_slot", 32'(rob.rob_alloc_resp_slot), 32'd0);
        alloc(5'd21);

        // reset with six in flight; stale fill afterwards is ignored
        do_reset();
        for (int i = 0; i < 6; i++) alloc(5'(i + 10));
        for (int i = 1; i < 5; i++) fill(4'(i), 32'(i * 16));
        do_reset();
        peek();
        chk("d_rst_rdy", 32'(rob.rob_alloc_req_rdy), 32'd1);
        chk("d_rst_tail", 32'(rob.rob_alloc_resp_slot), 32'd0);
        chk("d_rst_head", 32'(rob.rob_commit_slot), 32'd0);
        chk("d_rst_wen", 32'(rob.rob_commit_wen), 32'd0);
        fill(4'd4, 32'h00004444);
        peek();
        chk("d_stale_fill_wen", 32'(rob.rob_commit_wen), 32'd0);
        repeat (2) idle();

        // randomized traffic including stale fills and occasional reset
        for (int n = 0; n < 600; n++) begin
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                fs = 4'(q[$urandom_range(0, q.size() - 1)].slot);
            else
                fs = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 6,
                  5'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1,
                  fs,
                  $urandom,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
